keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans a 4x4 matrix keypad and debounces it. Translates each clean key press into the
//  gencon input stream: digit + one-cycle read_input strobe, one-hot operator, equal strobe.
//  Sits directly upstream of gencon; its outputs wire 1:1 to gencon's same-named inputs.
//  Layout, (row,col) = (0..3, 0..3):
//    row0: 1 2 3 A
//    row1: 4 5 6 B
//    row2: 7 8 9 C
//    row3: * 0 # D
//  Key functions: A=add(001), B=sub(010), C=mul(100); # and D = equal; * is ignored.
// PARAMETERS
//  SCAN_DIV         16      clk cycles each row is driven during scan (must be >= 4)
//  DEBOUNCE_CYCLES  50000   consecutive stable samples needed for press and for release (>= 2)
// PORTS
//  clk             in   1  system clock
//  RST             in   1  asynchronous reset, active-high
//  col_in          in   4  keypad columns; active-low, pulled up; asynchronous to clk
//  row_out         out  4  keypad row drive; active-low, one-hot-low
//  keypad_input    out  4  last digit pressed (0-9), held until the next digit
//  read_input      out  1  one-cycle strobe: keypad_input holds a new digit
//  operator_input  out  3  one-hot operator, held level; cleared on next digit or equal
//  equal_input     out  1  one-cycle strobe: equal key pressed
// BEHAVIOUR
//  Reset values (async on RST=1; also the values held while RST=1):
//   - row_out=4'b1110, keypad_input=0, read_input=0, operator_input=0, equal_input=0.
//   - FSM=SCAN, row index=0, all counters=0.
//  RST asserted mid-press or mid-debounce aborts everything; no strobe is produced.
//  col_in passes through a 2-flop synchronizer first; all logic uses col_s (2-cycle latency).
//  FSM states: SCAN, PRESS_DB, EMIT, WAIT_REL, REL_DB.
//  SCAN:
//   - Drive the current row for SCAN_DIV cycles; sample col_s on the last cycle of the window.
//   - Exactly one col_s bit low: latch the pattern, go to PRESS_DB, keep the row driven.
//   - Zero or multiple bits low: advance row (3 wraps to 0) and restart the window.
//  PRESS_DB:
//   - Counts cycles where col_s equals the latched pattern.
//   - Any mismatch: go to SCAN and advance row; no output.
//   - Count reaches DEBOUNCE_CYCLES: go to EMIT.
//  EMIT (one cycle): decode (row,col). Outputs register so they are visible the following cycle.
//   - Digit: keypad_input=digit, read_input=1 for exactly one cycle, operator_input=0.
//   - A/B/C: operator_input=one-hot; a new operator overwrites the previous one.
//   - # or D: equal_input=1 for exactly one cycle, operator_input=0.
//   - *: no output change.
//   - Go to WAIT_REL.
//  WAIT_REL: row stays driven; col_s==4'b1111 goes to REL_DB.
//   - No auto-repeat: a held key produces exactly one event.
//  REL_DB:
//   - Counts consecutive all-high cycles.
//   - Any low bit: back to WAIT_REL.
//   - Count reaches DEBOUNCE_CYCLES: go to SCAN at the next row, window restarted.
//  Ghosting: a second key pressed while the first is held is ignored until full release.
//  read_input and equal_input are never high in the same cycle; at most one strobe per press.
//  Counters are sized $clog2(max(SCAN_DIV,DEBOUNCE_CYCLES)+1) bits, saturate-free
//  (cleared on every state entry).
// STRUCTURE
//  Package keypad_pkg holds:
//   - state_t enum {SCAN, PRESS_DB, EMIT, WAIT_REL, REL_DB}.
//   - Op codes OP_ADD=3'b001, OP_SUB=3'b010, OP_MUL=3'b100.
//   - Key-code constants KEY_A..KEY_D, KEY_STAR, KEY_HASH, and the 16-entry keymap function.
//  One sub-module, keypad_sync: parameterised-width 2-flop synchronizer, async reset to all-ones.
// TESTING  (bench params SCAN_DIV=4, DEBOUNCE_CYCLES=8; keypad model pulls col low when its row is low)
//  1 Reset:
//    - Stimulus: RST pulse while '5' is mid-debounce.
//    - Response: row_out=1110 and all outputs 0 during reset; no read_input follows.
//  2 Clean digit:
//    - Stimulus: press '5' (row1,col1) for 200 cycles, release.
//    - Response: exactly one read_input pulse with keypad_input=5; no second pulse.
//  3 Bounce:
//    - Stimulus: '9' contact toggles every 3 cycles for 40 cycles, then stable.
//    - Response: exactly one read_input pulse, keypad_input=9.
//  4 Operator/digit:
//    - Stimulus: press 'A', release; then press '7'.
//    - Response: operator_input=001 held; on '7', read_input pulse, keypad_input=7, operator_input=000.
//  5 Equal:
//    - Stimulus: press 'B', release; then press 'D'.
//    - Response: operator_input=010, then equal_input single pulse and operator_input=000.
//  6 Rejects:
//    - Stimulus: keys '1'+'2' together; '*' alone; a 5-cycle '3' glitch.
//    - Response: no strobe and no output change in all three cases.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
//   Shared types and constants for the 4x4 keypad scanner.
//   - state_t   : scanner FSM states
//   - OP_*      : one-hot operator codes, same encoding as gencon expects
//   - KEY_*     : key codes for the non-digit keys (digits use their value)
//   - keymap()  : (row, col) -> key code for the physical keypad layout
//   - one_low() : true when exactly one column line is pulled low
//   - col_index(): position of the single low column bit
// ---------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [2:0] {
        SCAN,
        PRESS_DB,
        EMIT,
        WAIT_REL,
        REL_DB
    } state_t;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b100;

    // Codes 0..9 are the digits themselves; the rest sit above them.
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    // Physical layout:
    //   row0: 1 2 3 A
    //   row1: 4 5 6 B
    //   row2: 7 8 9 C
    //   row3: * 0 # D
    function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = KEY_A;
            4'd4:    code = 4'd4;
            4'd5:    code = 4'd5;
            4'd6:    code = 4'd6;
            4'd7:    code = KEY_B;
            4'd8:    code = 4'd7;
            4'd9:    code = 4'd8;
            4'd10:   code = 4'd9;
            4'd11:   code = KEY_C;
            4'd12:   code = KEY_STAR;
            4'd13:   code = 4'd0;
            4'd14:   code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

    function automatic logic one_low(input logic [3:0] cols);
        logic hit;
        case (cols)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
            default:                            hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic [1:0] col_index(input logic [3:0] pattern);
        logic [1:0] idx;
        case (pattern)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// ---------------------------------------------------------------------------
// keypad_sync
//   Two-flop synchronizer for asynchronous level inputs. Resets to all-ones
//   so idle (pulled-up) keypad columns read as "no key" out of reset.
//   clk   in  1      destination clock
//   rst   in  1      asynchronous reset, active-high
//   d     in  WIDTH  asynchronous input
//   q     out WIDTH  synchronized output (two-cycle latency)
// ---------------------------------------------------------------------------
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            // NOTE: non-blocking assignments make meta->q a true two-stage
            // shift; blocking here would collapse both flops into one.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//   Scans and debounces a 4x4 matrix keypad and turns each clean press into
//   the gencon input stream.
//   clk             in  1  system clock
//   RST             in  1  asynchronous reset, active-high
//   col_in          in  4  keypad columns, active-low, asynchronous
//   row_out         out 4  row drive, one-hot-low
//   keypad_input    out 4  last digit pressed, held
//   read_input      out 1  one-cycle strobe: new digit on keypad_input
//   operator_input  out 3  one-hot operator, held level
//   equal_input     out 1  one-cycle strobe: equal key pressed
// ---------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] keypad_input,
    output logic       read_input,
    output logic [2:0] operator_input,
    output logic       equal_input
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    col_s;
    state_t        state, state_next;
    logic [1:0]    row_idx, row_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [3:0]    pattern, pattern_next;
    logic [3:0]    keypad_next;
    logic          read_next;
    logic [2:0]    operator_next;
    logic          equal_next;
    logic [3:0]    key;

    keypad_sync #(.WIDTH(4)) u_sync (
        .clk (clk),
        .rst (RST),
        .d   (col_in),
        .q   (col_s)
    );

    assign row_out = ~(4'b0001 << row_idx);

    // State register, scan datapath and registered outputs.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state          <= SCAN;
            row_idx        <= '0;
            cnt            <= '0;
            pattern        <= 4'b1111;
            keypad_input   <= '0;
            read_input     <= 1'b0;
            operator_input <= OP_NONE;
            equal_input    <= 1'b0;
        end else begin
            state          <= state_next;
            row_idx        <= row_next;
            cnt            <= cnt_next;
            pattern        <= pattern_next;
            keypad_input   <= keypad_next;
            read_input     <= read_next;
            operator_input <= operator_next;
            equal_input    <= equal_next;
        end
    end

    // Next-state logic. The counter is cleared on every state change, so it
    // never needs to saturate. The row only advances when leaving a key
    // (reject, bounce or full release), so the pressed row stays driven.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case leaves a signal unassigned (no latches).
        state_next   = state;
        row_next     = row_idx;
        cnt_next     = cnt + 1'b1;
        pattern_next = pattern;
        case (state)
            SCAN: begin
                if (cnt == SCAN_LAST) begin
                    cnt_next = '0;
                    if (one_low(col_s)) begin
                        state_next   = PRESS_DB;
                        pattern_next = col_s;
                    end else begin
                        row_next = row_idx + 2'd1;
                    end
                end
            end
            PRESS_DB: begin
                if (col_s != pattern) begin
                    state_next = SCAN;
                    row_next   = row_idx + 2'd1;
                    cnt_next   = '0;
                end else if (cnt == DB_LAST) begin
                    state_next = EMIT;
                    cnt_next   = '0;
                end
            end
            EMIT: begin
                state_next = WAIT_REL;
                cnt_next   = '0;
            end
            WAIT_REL: begin
                cnt_next = '0;
                if (col_s == 4'b1111) state_next = REL_DB;
            end
            REL_DB: begin
                if (col_s != 4'b1111) begin
                    state_next = WAIT_REL;
                    cnt_next   = '0;
                end else if (cnt == DB_LAST) begin
                    state_next = SCAN;
                    row_next   = row_idx + 2'd1;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = SCAN;
                cnt_next   = '0;
            end
        endcase
    end

    // Output logic: only EMIT changes anything; strobes fall back to 0.
    always_comb begin
        key           = keymap(row_idx, col_index(pattern));
        keypad_next   = keypad_input;
        read_next     = 1'b0;
        operator_next = operator_input;
        equal_next    = 1'b0;
        if (state == EMIT) begin
            case (key)
                KEY_A: operator_next = OP_ADD;
                KEY_B: operator_next = OP_SUB;
                KEY_C: operator_next = OP_MUL;
                KEY_D, KEY_HASH: begin
                    equal_next    = 1'b1;
                    operator_next = OP_NONE;
                end
                KEY_STAR: ;
                default: begin
                    keypad_next   = key;
                    read_next     = 1'b1;
                    operator_next = OP_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//   Drives a behavioural 4x4 keypad (a column reads low when a pressed key's
//   row is driven low). Expected strobes are queued as keys are pressed; a
//   monitor pops and compares each strobe the scanner presents.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        RST;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  keypad_input;
    logic        read_input;
    logic [2:0]  operator_input;
    logic        equal_input;
    logic [15:0] pressed;   // index = row*4 + col

    typedef struct packed {
        logic       is_eq;
        logic [3:0] val;
        logic [2:0] op;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk            (clk),
        .RST            (RST),
        .col_in         (col_in),
        .row_out        (row_out),
        .keypad_input   (keypad_input),
        .read_input     (read_input),
        .operator_input (operator_input),
        .equal_input    (equal_input)
    );

    always #5 clk = ~clk;

    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(input int k, input int hold);
        pressed[k] = 1'b1;
        wait_cyc(hold);
        pressed[k] = 1'b0;
        wait_cyc(60);
    endtask

    task automatic push(input logic is_eq, input logic [3:0] val, input logic [2:0] op);
        ev_t e;
        e.is_eq = is_eq;
        e.val   = val;
        e.op    = op;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every strobe must match the oldest queued event.
    always @(negedge clk) begin
        if (!RST && (read_input || equal_input)) begin
            check("strobes exclusive", {7'd0, read_input & equal_input}, 8'd0);
            if (exp_q.size() == 0) begin
                check("strobe with empty queue", 8'(exp_q.size()), 8'd1);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("strobe is equal", {7'd0, equal_input}, {7'd0, e.is_eq});
                check("keypad_input at strobe", {4'd0, keypad_input}, {4'd0, e.val});
                check("operator_input at strobe", {5'd0, operator_input}, {5'd0, e.op});
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, " row_out"}, {4'd0, row_out}, 8'h0E);
        check({tag, " keypad_input"}, {4'd0, keypad_input}, 8'd0);
        check({tag, " read_input"}, {7'd0, read_input}, 8'd0);
        check({tag, " operator_input"}, {5'd0, operator_input}, 8'd0);
        check({tag, " equal_input"}, {7'd0, equal_input}, 8'd0);
    endtask

    initial begin
        pressed = '0;
        RST     = 1'b1;

        // 1: reset, including a reset that lands while '5' is debouncing
        wait_cyc(3);
        check_reset_values("reset");
        RST = 1'b0;
        pressed[5] = 1'b1;
        wait_cyc(12);
        RST = 1'b1;
        wait_cyc(2);
        check_reset_values("mid-debounce reset");
        pressed[5] = 1'b0;
        wait_cyc(2);
        RST = 1'b0;
        wait_cyc(60);
        check("no strobe after reset", 8'(exp_q.size()), 8'd0);

        // 2: clean '5'
        push(1'b0, 4'd5, 3'b000);
        tap(5, 200);
        check("clean 5 drained", 8'(exp_q.size()), 8'd0);
        check("clean 5 held", {4'd0, keypad_input}, 8'd5);

        // 3: bouncing '9' (row2,col2) settles to one press
        push(1'b0, 4'd9, 3'b000);
        repeat (13) begin
            pressed[10] = ~pressed[10];
            wait_cyc(3);
        end
        pressed[10] = 1'b1;
        wait_cyc(200);
        pressed[10] = 1'b0;
        wait_cyc(60);
        check("bounce 9 drained", 8'(exp_q.size()), 8'd0);

        // 4: 'A' then '7'
        tap(3, 200);
        check("op after A", {5'd0, operator_input}, 8'h01);
        check("digit kept after A", {4'd0, keypad_input}, 8'd9);
        push(1'b0, 4'd7, 3'b000);
        tap(8, 200);
        check("digit 7 drained", 8'(exp_q.size()), 8'd0);
        check("op cleared by 7", {5'd0, operator_input}, 8'h00);

        // 5: 'B' then 'D'
        tap(7, 200);
        check("op after B", {5'd0, operator_input}, 8'h02);
        push(1'b1, 4'd7, 3'b000);
        tap(15, 200);
        check("equal D drained", 8'(exp_q.size()), 8'd0);
        check("op cleared by D", {5'd0, operator_input}, 8'h00);

        // 6: rejects, with 'C' latched first so a spurious clear shows up
        tap(11, 200);
        check("op after C", {5'd0, operator_input}, 8'h04);
        pressed[0] = 1'b1;
        pressed[1] = 1'b1;
        wait_cyc(200);
        pressed[0] = 1'b0;
        pressed[1] = 1'b0;
        wait_cyc(60);
        tap(12, 200);
        pressed[2] = 1'b1;
        wait_cyc(5);
        pressed[2] = 1'b0;
        wait_cyc(60);
        check("rejects no strobe", 8'(exp_q.size()), 8'd0);
        check("rejects op held", {5'd0, operator_input}, 8'h04);
        check("rejects digit held", {4'd0, keypad_input}, 8'd7);

        // '#' is also equal and clears the operator
        push(1'b1, 4'd7, 3'b000);
        tap(14, 200);
        check("equal # drained", 8'(exp_q.size()), 8'd0);
        check("op cleared by #", {5'd0, operator_input}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
